neuron_pe: RTL and testbench
============================

NEURON_PE -- requirements
Module: neuron_pe

Interface
REQ-001 SHALL have parameter LAYER_NO, default 1, meaning layer ID this neuron answers to.
REQ-002 SHALL have parameter NEURON_NO, default 0, meaning neuron ID within layer.
REQ-003 SHALL have parameter NUM_WEIGHT, default 784, meaning inputs/weights per inference (>=2).
REQ-004 SHALL have parameter DATA_WIDTH, default 16, meaning signed input/weight/output width.
REQ-005 SHALL have parameter INT_WIDTH, default 1, meaning integer bits; FRAC = DATA_WIDTH-1-INT_WIDTH.
REQ-006 SHALL have parameter ACT_MODE, default 0, meaning 0 = ReLU, 1 = linear (saturating).
REQ-007 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-low reset.
REQ-008 SHALL have ports: weight_valid  in  1  weight write strobe; bias_valid  in  1  bias write strobe.
REQ-009 SHALL have ports: weight_value, bias_value  in  32  load data (low DATA_WIDTH bits used); config_layer_num, config_neuron_num  in  32  load target.
REQ-010 SHALL have ports: in_data  in  DATA_WIDTH  input sample; in_valid  in  1  sample valid; in_ready  out  1  sample accepted when high with in_valid.
REQ-011 SHALL have ports: out  out  DATA_WIDTH  activated result; out_valid  out  1  one-cycle result strobe; busy  out  1  state != IDLE.

Function
REQ-012 Weight/bias loads SHALL be accepted only when config_layer_num==LAYER_NO and config_neuron_num==NEURON_NO and state==IDLE; otherwise ignored.
REQ-013 Weight write pointer SHALL start at 0, increment per accepted write, wrap NUM_WEIGHT-1 -> 0.
REQ-014 Weight memory SHALL be NUM_WEIGHT x DATA_WIDTH, one write port, one synchronous read port (1-cycle latency).
REQ-015 FSM states SHALL be IDLE, ACCUM, BIAS, ACT; IDLE->ACCUM on first accepted sample; ACCUM->BIAS when the NUM_WEIGHT-th product is accumulated; BIAS->ACT next cycle; ACT->IDLE next cycle.
REQ-016 in_ready SHALL be high in IDLE and in ACCUM until NUM_WEIGHT samples accepted, low otherwise; in_valid gaps SHALL be tolerated (no sample lost, no double count).
REQ-017 Pipeline SHALL be: edge N sample + weight read; N+1 signed product (2*DATA_WIDTH) registered; N+2 accumulate; last sample at edge N -> out/out_valid update at edge N+4.
REQ-018 Accumulator SHALL be 2*DATA_WIDTH signed, saturating to max/min on positive/negative overflow, cleared on entry to ACCUM.
REQ-019 BIAS state SHALL add sign-extended bias << FRAC to the accumulator with the same saturation.
REQ-020 ACT SHALL compute acc >>> FRAC saturated to DATA_WIDTH signed; ReLU additionally forces negative results to 0.
REQ-021 out SHALL hold its value until the next result; out_valid SHALL be high for exactly one cycle.
REQ-022 Read address SHALL return to 0 on leaving ACT so back-to-back inferences need no reload.

Reset
REQ-023 On rst low at a clock edge: state IDLE, read/write pointers 0, accumulator 0, out 0, out_valid 0, busy 0, in_ready 1 after release.
REQ-024 Reset mid-inference SHALL abort with no out_valid; weight memory and bias contents SHALL be retained.

Configuration
REQ-025 With NEURON_PE_BIAS_EN defined, bias register (reset 0) SHALL load via bias_valid per REQ-012 and BIAS adds it; without it, bias_valid is ignored, bias is constant 0, BIAS state still occupies one cycle (latency unchanged).

Structure
REQ-026 Package neuron_pkg SHALL hold the FSM state enum, ACT_RELU/ACT_LINEAR constants and a saturating-add function.
REQ-027 Weight memory SHALL be sub-module neuron_wmem (params depth, data width).

Verification (DATA_WIDTH=16, NUM_WEIGHT=4, INT_WIDTH=1, FRAC=14)
REQ-028 Weights 0x1000 x4, inputs 0x4000 x4 back-to-back, bias 0 -> out 0x4000, out_valid one cycle, 4 edges after last input.
REQ-029 As REQ-028 with bias 0x1000 (macro defined) -> out 0x5000; macro undefined -> out 0x4000.
REQ-030 Weights 0x2000, inputs 0x4000 -> out 0x7FFF (output saturation); weights 0xF000 -> ReLU 0x0000, linear 0xC000.
REQ-031 Inputs with in_valid gaps (1,0,1,0,1,1) -> same result as back-to-back; in_ready low from 4th accept until IDLE.
REQ-032 Weight write with mismatched neuron ID or while busy -> memory unchanged; rst low during ACCUM -> no out_valid, next inference uses retained weights correctly.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron processing element:
// FSM state encoding, activation-mode constants and a width-generic
// saturating adder used by the accumulator.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    ACT   = 2'd3
  } state_t;

  localparam int ACT_RELU   = 0;
  localparam int ACT_LINEAR = 1;

  // Widest accumulator the saturating adder can serve.
  localparam int SAT_MAX_W = 64;

  // Adds two sign-extended operands and clamps the sum to the signed
  // range of a w-bit result (w <= SAT_MAX_W).
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
    input logic signed [SAT_MAX_W-1:0] a,
    input logic signed [SAT_MAX_W-1:0] b,
    input int                          w
  );
    logic signed [SAT_MAX_W:0] sum;
    logic signed [SAT_MAX_W:0] one;
    logic signed [SAT_MAX_W:0] lim;
    logic signed [SAT_MAX_W:0] tmp;
    one    = '0;
    one[0] = 1'b1;
    sum    = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
    lim    = one <<< (w - 1);
    if (sum >= lim) begin
      tmp = lim - one;
    end else if (sum < -lim) begin
      tmp = -lim;
    end else begin
      tmp = sum;
    end
    return tmp[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/neuron_wmem.sv
// Weight store for one neuron: DEPTH x DATA_WIDTH, one write port and
// one registered read port (data valid the cycle after rd_en).
module neuron_wmem #(
  parameter int DEPTH      = 784,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is intentionally not reset so weights survive an aborted inference.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/neuron_pe.sv
// Single neuron processing element: streams NUM_WEIGHT samples, multiplies
// each by a stored weight, accumulates with saturation, adds a bias and
// applies ReLU or saturating linear activation.
// Optional feature macro: NEURON_PE_BIAS_EN enables a loadable bias
// register; without it the bias is fixed at zero (BIAS cycle still spent).
module neuron_pe
  import neuron_pkg::*;
#(
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0,
  parameter int NUM_WEIGHT = 784,
  parameter int DATA_WIDTH = 16,
  parameter int INT_WIDTH  = 1,
  parameter int ACT_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         weight_valid,
  input  logic                         bias_valid,
  input  logic [31:0]                  weight_value,
  input  logic [31:0]                  bias_value,
  input  logic [31:0]                  config_layer_num,
  input  logic [31:0]                  config_neuron_num,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        out,
  output logic                         out_valid,
  output logic                         busy
);

  localparam int FRAC  = DATA_WIDTH - 1 - INT_WIDTH;
  localparam int ACC_W = 2 * DATA_WIDTH;
  localparam int AW    = $clog2(NUM_WEIGHT);
  localparam int CW    = $clog2(NUM_WEIGHT + 1);

  state_t state_q, state_d;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] accept_cnt, acc_cnt;
  logic          cfg_match, weight_we, accept, last_prod;

  logic                         vld_p0, vld_p1;
  logic signed [DATA_WIDTH-1:0] x_p0;
  logic signed [DATA_WIDTH-1:0] w_p0;
  logic signed [ACC_W-1:0]      prod_p1;
  logic signed [ACC_W-1:0]      acc_p2;
  logic signed [DATA_WIDTH-1:0] bias_q;
  logic signed [ACC_W-1:0]      bias_term;
  logic                         unused_bits;

  // Saturating accumulate at ACC_W bits.
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [SAT_MAX_W-1:0] s;
    s = sat_add(SAT_MAX_W'(a), SAT_MAX_W'(b), ACC_W);
    return s[ACC_W-1:0];
  endfunction

  // Rescale the accumulator back to the data format, clamp, then rectify.
  function automatic logic signed [DATA_WIDTH-1:0] activate(
    input logic signed [ACC_W-1:0] a
  );
    logic signed [ACC_W-1:0]      s, hi, lo;
    logic signed [DATA_WIDTH-1:0] r;
    s                 = a >>> FRAC;
    hi                = '0;
    hi[DATA_WIDTH-2:0] = '1;
    lo                = '1;
    lo[DATA_WIDTH-2:0] = '0;
    if (s > hi) begin
      r = hi[DATA_WIDTH-1:0];
    end else if (s < lo) begin
      r = lo[DATA_WIDTH-1:0];
    end else begin
      r = s[DATA_WIDTH-1:0];
    end
    if (ACT_MODE == ACT_RELU && r[DATA_WIDTH-1]) begin
      r = '0;
    end
    return r;
  endfunction

  assign cfg_match = (config_layer_num == 32'(LAYER_NO)) &&
                     (config_neuron_num == 32'(NEURON_NO));
  assign weight_we = weight_valid && cfg_match && (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_prod = vld_p1 && (acc_cnt == CW'(NUM_WEIGHT - 1));
  assign busy      = (state_q != IDLE);
  assign bias_term = ACC_W'(bias_q) <<< FRAC;
  assign unused_bits = ^{weight_value, bias_value, bias_valid};

`ifdef NEURON_PE_BIAS_EN
  // Bias register loads under the same addressing rule as the weights.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bias_q <= '0;
    end else if (bias_valid && cfg_match && (state_q == IDLE)) begin
      bias_q <= bias_value[DATA_WIDTH-1:0];
    end
  end
`else
  assign bias_q = '0;
`endif

  neuron_wmem #(
    .DEPTH      (NUM_WEIGHT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wmem (
    .clk     (clk),
    .wr_en   (weight_we),
    .wr_addr (wr_ptr),
    .wr_data (weight_value[DATA_WIDTH-1:0]),
    .rd_en   (accept),
    .rd_addr (rd_ptr),
    .rd_data (w_p0)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and input handshake.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ACCUM;
      end
      ACCUM: begin
        in_ready = (accept_cnt < CW'(NUM_WEIGHT));
        if (last_prod) state_d = BIAS;
      end
      BIAS:    state_d = ACT;
      ACT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write/read pointers and sample/product counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      accept_cnt <= '0;
      acc_cnt    <= '0;
    end else begin
      if (weight_we) begin
        wr_ptr <= (wr_ptr == AW'(NUM_WEIGHT - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (accept) begin
        rd_ptr     <= (rd_ptr == AW'(NUM_WEIGHT - 1)) ? '0 : rd_ptr + 1'b1;
        accept_cnt <= (state_q == IDLE) ? CW'(1) : accept_cnt + 1'b1;
      end else if (state_q == ACT) begin
        rd_ptr <= '0;
      end
      if (accept && (state_q == IDLE)) begin
        acc_cnt <= '0;
      end else if (vld_p1) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end

  // ---- stage p0: sample captured alongside the weight read ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept;
    end
  end

  // Sample data register (data path, no reset).
  always_ff @(posedge clk) begin
    if (accept) begin
      x_p0 <= in_data;
    end
  end

  // ---- stage p1: full-width signed product ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  // Product register (data path, no reset).
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      prod_p1 <= ACC_W'(x_p0) * ACC_W'(w_p0);
    end
  end

  // ---- stage p2: saturating accumulate, then bias in the BIAS cycle ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_p2 <= '0;
    end else if (accept && (state_q == IDLE)) begin
      acc_p2 <= '0;
    end else if (vld_p1) begin
      acc_p2 <= acc_add(acc_p2, prod_p1);
    end else if (state_q == BIAS) begin
      acc_p2 <= acc_add(acc_p2, bias_term);
    end
  end

  // ---- output: activation result held until the next inference ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_q == ACT);
      if (state_q == ACT) begin
        out <= activate(acc_p2);
      end
    end
  end

endmodule

// File: tb/tb_neuron_pe.sv
// Self-checking bench for neuron_pe (NUM_WEIGHT=4, DATA_WIDTH=16, FRAC=14).
// Two instances share all inputs: one ReLU, one linear activation.
`timescale 1ns/1ps
module tb_neuron_pe;

  localparam int DW = 16;
  localparam int NW = 4;
  localparam longint AMAX = 64'sh7FFF_FFFF;
  localparam longint AMIN = -64'sh8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          weight_valid = 1'b0;
  logic          bias_valid = 1'b0;
  logic [31:0]   weight_value = '0;
  logic [31:0]   bias_value = '0;
  logic [31:0]   config_layer_num = '0;
  logic [31:0]   config_neuron_num = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;

  logic          in_ready_r, out_valid_r, busy_r;
  logic          in_ready_l, out_valid_l, busy_l;
  logic [DW-1:0] out_r, out_l;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  logic signed [DW-1:0] wm [NW];
  logic signed [DW-1:0] xq [NW];
  logic signed [DW-1:0] bias_m = '0;

  typedef struct {
    logic [DW-1:0] exp_r;
    logic [DW-1:0] exp_l;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  neuron_pe #(.LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(NW), .DATA_WIDTH(DW),
              .INT_WIDTH(1), .ACT_MODE(0)) dut_relu (
    .clk(clk), .rst(rst), .weight_valid(weight_valid), .bias_valid(bias_valid),
    .weight_value(weight_value), .bias_value(bias_value),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_r),
    .out(out_r), .out_valid(out_valid_r), .busy(busy_r));

  neuron_pe #(.LAYER_NO(1), .NEURON_NO(0), .NUM_WEIGHT(NW), .DATA_WIDTH(DW),
              .INT_WIDTH(1), .ACT_MODE(1)) dut_lin (
    .clk(clk), .rst(rst), .weight_valid(weight_valid), .bias_valid(bias_valid),
    .weight_value(weight_value), .bias_value(bias_value),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
    .out(out_l), .out_valid(out_valid_l), .busy(busy_l));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint clip(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: Q1.14 dot product, 32-bit saturating accumulate, bias, rescale.
  function automatic logic [DW-1:0] model(input bit linear);
    longint acc;
    longint r;
    acc = 0;
    for (int i = 0; i < NW; i++) begin
      acc = clip(acc + longint'(wm[i]) * longint'(xq[i]), AMIN, AMAX);
    end
    acc = clip(acc + longint'(bias_m) * 16384, AMIN, AMAX);
    r = acc >>> 14;
    r = clip(r, -32768, 32767);
    if (!linear && r < 0) r = 0;
    return r[DW-1:0];
  endfunction

  // Result monitor: pops the scoreboard on every out_valid.
  logic          prev_valid = 1'b0;
  logic [DW-1:0] held = '0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (prev_valid) begin
      checks++;
      if (out_valid_r !== 1'b0 || out_r !== held) begin
        failures++;
        $display("FAIL pulse_hold out_valid=%b out=%h required out_valid=0 out=%h",
                 out_valid_r, out_r, held);
      end
    end
    prev_valid = (out_valid_r === 1'b1);
    if (out_valid_r === 1'b1) begin
      held = out_r;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out_valid at cycle %0d out=%h required no result", cyc, out_r);
      end else begin
        e = sb.pop_front();
        if (out_r !== e.exp_r) begin
          failures++;
          $display("FAIL out_relu got=%h required=%h", out_r, e.exp_r);
        end
        checks++;
        if (out_valid_l !== 1'b1 || out_l !== e.exp_l) begin
          failures++;
          $display("FAIL out_linear got=%h valid=%b required=%h valid=1", out_l, out_valid_l, e.exp_l);
        end
        checks++;
        if (cyc !== e.cyc + 4) begin
          failures++;
          $display("FAIL latency got=%0d edges required=4", cyc - e.cyc);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic write_weight(input logic [DW-1:0] w, input int layer, input int neuron);
    weight_value      = {16'h0, w};
    config_layer_num  = layer;
    config_neuron_num = neuron;
    weight_valid      = 1'b1;
    @(posedge clk);
    #1;
    weight_valid = 1'b0;
  endtask

  task automatic write_bias(input logic [DW-1:0] b);
    bias_value        = {16'h0, b};
    config_layer_num  = 1;
    config_neuron_num = 0;
    bias_valid        = 1'b1;
    @(posedge clk);
    #1;
    bias_valid = 1'b0;
`ifdef NEURON_PE_BIAS_EN
    bias_m = b;
`endif
  endtask

  task automatic load_weights(input logic [DW-1:0] w0, w1, w2, w3);
    write_weight(w0, 1, 0); wm[0] = w0;
    write_weight(w1, 1, 0); wm[1] = w1;
    write_weight(w2, 1, 0); wm[2] = w2;
    write_weight(w3, 1, 0); wm[3] = w3;
  endtask

  task automatic send(input logic [DW-1:0] x);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    in_data  = x;
    in_valid = 1'b1;
    while (!ok && n < 50) begin
      ok = (in_ready_r === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    last_acc_cyc = cyc;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout accepted=0 required=1");
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected();
    exp_t e;
    e.exp_r = model(1'b0);
    e.exp_l = model(1'b1);
    e.cyc   = last_acc_cyc;
    sb.push_back(e);
  endtask

  task automatic run4(input logic [DW-1:0] x0, x1, x2, x3);
    xq[0] = x0; xq[1] = x1; xq[2] = x2; xq[3] = x3;
    send(x0); send(x1); send(x2); send(x3);
    push_expected();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy_r !== 1'b0) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_r !== 16'h0) begin failures++; $display("FAIL reset_out got=%h required=0000", out_r); end
    checks++; if (out_valid_r !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b required=0", out_valid_r); end
    checks++; if (busy_r !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy_r); end
    checks++; if (in_ready_r !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b required=1", in_ready_r); end
    checks++; if (out_l !== 16'h0) begin failures++; $display("FAIL reset_out_lin got=%h required=0000", out_l); end
  endtask

  task automatic test_basic();
    load_weights(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    run4(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    checks++;
    if (busy_r !== 1'b1 || in_ready_r !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy busy=%b in_ready=%b required busy=1 in_ready=0", busy_r, in_ready_r);
    end
    wait_drain();
    checks++;
    if (out_r !== 16'h4000) begin failures++; $display("FAIL basic_value got=%h required=4000", out_r); end
  endtask

  task automatic test_bias();
    write_bias(16'h1000);
    run4(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    wait_drain();
    write_bias(16'h0000);
  endtask

  task automatic test_saturation();
    load_weights(16'h2000, 16'h2000, 16'h2000, 16'h2000);
    run4(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    wait_drain();
    checks++;
    if (out_r !== 16'h7FFF) begin failures++; $display("FAIL out_sat got=%h required=7fff", out_r); end
    load_weights(16'hF000, 16'hF000, 16'hF000, 16'hF000);
    run4(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    wait_drain();
    checks++;
    if (out_r !== 16'h0000 || out_l !== 16'hC000) begin
      failures++;
      $display("FAIL negative relu=%h linear=%h required relu=0000 linear=c000", out_r, out_l);
    end
    // Products of 0x8000*0x8000 overflow the 32-bit accumulator.
    load_weights(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    run4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    wait_drain();
  endtask

  task automatic test_gaps();
    bit bad;
    int n;
    load_weights(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    xq[0] = 16'h4000; xq[1] = 16'h4000; xq[2] = 16'h4000; xq[3] = 16'h4000;
    send(16'h4000); idle_cycle();
    send(16'h4000); idle_cycle();
    send(16'h4000);
    send(16'h4000);
    push_expected();
    bad = 1'b0;
    n = 0;
    while (busy_r === 1'b1 && n < 20) begin
      if (in_ready_r !== 1'b0) bad = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL gap_in_ready got=1 required=0 while busy"); end
    checks++;
    if (in_ready_r !== 1'b1 || busy_r !== 1'b0) begin
      failures++;
      $display("FAIL gap_idle in_ready=%b busy=%b required in_ready=1 busy=0", in_ready_r, busy_r);
    end
    wait_drain();
    checks++;
    if (out_r !== 16'h4000) begin failures++; $display("FAIL gap_value got=%h required=4000", out_r); end
  endtask

  task automatic test_back_to_back();
    load_weights(16'h1000, 16'h2000, 16'hF000, 16'h0800);
    for (int k = 0; k < 3; k++) begin
      run4(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
           16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    end
    wait_drain();
  endtask

  task automatic test_load_reject();
    for (int i = 0; i < NW; i++) write_weight(16'h7000, 1, 5);
    for (int i = 0; i < NW; i++) write_weight(16'h7000, 2, 0);
    xq[0] = 16'h2000; xq[1] = 16'h4000; xq[2] = 16'hC000; xq[3] = 16'h3000;
    send(xq[0]);
    send(xq[1]);
    for (int i = 0; i < NW; i++) write_weight(16'h7000, 1, 0);
    send(xq[2]);
    send(xq[3]);
    push_expected();
    wait_drain();
    // A fresh load must still start at address 0.
    load_weights(16'h1000, 16'h0000, 16'h0000, 16'h0000);
    run4(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    wait_drain();
    checks++;
    if (out_r !== 16'h1000) begin failures++; $display("FAIL reload_align got=%h required=1000", out_r); end
  endtask

  task automatic test_reset_abort();
    load_weights(16'h1000, 16'h2000, 16'h0800, 16'hF800);
    send(16'h4000); send(16'h4000); send(16'h4000); send(16'h4000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checks++;
    if (busy_r !== 1'b0 || in_ready_r !== 1'b1 || out_valid_r !== 1'b0) begin
      failures++;
      $display("FAIL abort_state busy=%b in_ready=%b out_valid=%b required 0/1/0",
               busy_r, in_ready_r, out_valid_r);
    end
    repeat (8) idle_cycle();
    run4(16'h4000, 16'h2000, 16'h4000, 16'h4000);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias();
    test_saturation();
    test_gaps();
    test_back_to_back();
    test_load_reject();
    test_reset_abort();
    repeat (5) idle_cycle();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL final_scoreboard pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
